rp_sd_requester: RTL and testbench
==================================

Name: rp_sd_requester

Overview:
- Drive-side requester for the shared SD controller, one instance per RPxx drive, bit i of the 8-bit request/acknowledge bus.
- Latches a disk operation from the drive command decoder and raises sdREQ. It waits for the round-robin arbiter's sdACK, then issues one start pulse to the SD controller and waits for completion.
- It drops sdREQ and waits for the arbiter to withdraw sdACK before accepting new work.
- It also reports busy, done and error status back to the drive registers.

Parameters:
- TIMEOUT, 1000000, clocks allowed between sdSTART and sdDONE before a timeout error; counter width is clog2(TIMEOUT).

Ports:
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-high
- clr  input  1  drive clear, synchronous, cancels a not-yet-granted request
- cmdGO  input  1  one-cycle pulse: start operation
- cmdFUN  input  2  operation: 0 read, 1 write, 2 write-check, 3 reserved
- cmdSECT  input  32  LBA sector address
- sdREQ  output  1  request to the arbiter
- sdACK  input  1  grant from the arbiter
- sdSTART  output  1  one-cycle pulse to the SD controller
- sdOP  output  2  latched cmdFUN, stable from grant until release
- sdSECT  output  32  latched cmdSECT, stable from grant until release
- sdDONE  input  1  one-cycle completion pulse from the SD controller
- sdERR  input  1  error qualifier, valid with sdDONE
- busy  output  1  operation pending or active
- done  output  1  one-cycle completion pulse to the drive
- err  output  1  sticky error: SD error, timeout, lost grant, or illegal function
- rjt  output  1  one-cycle pulse: cmdGO rejected

Behaviour:
- Reset values: sdREQ, sdSTART, busy, done, err and rjt are 0; sdOP and sdSECT are 0; state is IDLE; timeout counter is 0.
- States and transitions:
  - IDLE:
    - On cmdGO with cmdFUN≠3: latch fun/sect, set sdREQ=1 and busy=1 next cycle (1-cycle latency), go to REQ.
    - On cmdGO with cmdFUN=3: pulse rjt, set err, stay in IDLE.
    - While sdACK is 1 (stale grant), cmdGO is still accepted, but REQ waits for a fresh grant (see RELEASE).
  - REQ:
    - Hold sdREQ until sdACK=1.
    - On sdACK: next cycle pulse sdSTART for exactly 1 clock, clear the counter, go to BUSY.
    - On clr (without sdACK in the same cycle): drop sdREQ and busy, go to IDLE with no done pulse.
    - clr and sdACK in the same cycle: grant wins; clr is ignored.
  - BUSY:
    - The counter increments every clock.
    - On sdDONE: drop sdREQ, pulse done, set err if sdERR, go to RELEASE.
    - If the counter reaches TIMEOUT-1 without sdDONE: same as sdDONE with error.
    - If sdACK falls while in BUSY (protocol violation): set err, drop sdREQ, pulse done, go to RELEASE.
    - clr is ignored in BUSY: an SD transfer cannot be aborted.
  - RELEASE:
    - Wait for sdACK=0, then clear busy and go to IDLE.
    - The arbiter takes at least 1 clock to drop sdACK after sdREQ falls, so RELEASE lasts ≥1 cycle.
- Handshake ordering:
  - sdREQ rises only from IDLE and falls only on completion, clr, or a protocol error.
  - sdREQ never re-asserts while sdACK is still high, so no stale grant is reused.
- cmdGO while busy=1 is ignored: pulse rjt, latched values unchanged, err unchanged.
- sdDONE outside BUSY is ignored.
- err is cleared only by rst, or by clr in IDLE or REQ. A command accepted in IDLE does not clear err.
- done and sdSTART never assert in the same cycle.

Decomposition:
- Shared package rh_sd_pkg:
  - function codes (sdopREAD=0, sdopWRITE=1, sdopWRCHK=2)
  - state encodings
  - sector width (32)
  - request bus width (8)
- The arbiter side uses the same package.
- A single sub-module, rp_sd_timeout, holds the loadable timeout counter (clear, enable, expire output).
- The FSM and latches stay in the top module.

Test Plan:
- Basic read: cmdGO, fun=0, sect=0x00001234. Arbiter model grants 3 clocks after REQ; SD model pulses sdDONE 10 clocks after sdSTART, sdERR=0.
  - Expect REQ 1 clock after GO.
  - Expect sdSTART exactly 1 clock after ACK, with sdOP=0 and sdSECT=0x00001234.
  - Expect done 1 clock after sdDONE, REQ low the same cycle, busy low after ACK falls, err=0.
- SD error: as above, but sdDONE with sdERR=1 → err=1 and done pulse. A following cmdGO completes normally and err stays 1 until clr.
- Timeout: TIMEOUT=16, SD model never completes → done and err asserted 15 clocks after the sdSTART cycle, then REQ=0.
- Reject and illegal function:
  - cmdGO during BUSY with fun=1, sect=5 → rjt pulse, sdOP/sdSECT unchanged.
  - cmdGO in IDLE with fun=3 → rjt, err=1, no REQ.
- Clear while pending: cmdGO, arbiter withholds ACK, clr at REQ+2 → REQ low, busy low, no sdSTART, no done. Repeat with clr in the same cycle as ACK → transfer proceeds.
- Lost grant and eight-drive arbitration:
  - Drop ACK mid-BUSY → err=1, done, REQ=0.
  - Eight instances with round-robin arbiter, all GO simultaneously → each completes exactly once, grants in scan order, never two ACKs high.

Source files
------------

// File: rtl/rh_sd_pkg.sv
// Shared definitions for the RPxx drive requesters and the SD round-robin arbiter.
package rh_sd_pkg;

  localparam int unsigned SECT_W = 32;
  localparam int unsigned REQ_W  = 8;

  typedef enum logic [1:0] {
    sdopREAD  = 2'd0,
    sdopWRITE = 2'd1,
    sdopWRCHK = 2'd2,
    sdopRSVD  = 2'd3
  } sd_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_BUSY,
    ST_RELEASE
  } sd_state_e;

endpackage

// File: rtl/rp_sd_timeout.sv
// Loadable watchdog counter for one SD transfer; expire flags the transfer as overdue.
module rp_sd_timeout #(
  parameter int unsigned TIMEOUT = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int unsigned W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  // Fires one count early: the requester registers done, so it lands on the TIMEOUT-1 edge.
  localparam logic [W-1:0] LAST = W'(TIMEOUT - 2);

  logic [W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      count <= '0;
    else if (clear)
      count <= '0;
    else if (enable)
      count <= count + 1'b1;
  end

  assign expire = enable && (count == LAST);

endmodule

// File: rtl/rp_sd_requester.sv
// Drive-side requester: latches a disk command, arbitrates for the shared SD
// controller, issues one start pulse and reports busy/done/err to the drive.
module rp_sd_requester
  import rh_sd_pkg::*;
#(
  parameter int unsigned TIMEOUT = 1000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              cmdGO,
  input  logic [1:0]        cmdFUN,
  input  logic [SECT_W-1:0] cmdSECT,
  output logic              sdREQ,
  input  logic              sdACK,
  output logic              sdSTART,
  output logic [1:0]        sdOP,
  output logic [SECT_W-1:0] sdSECT,
  input  logic              sdDONE,
  input  logic              sdERR,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              rjt
);

  sd_state_e state;
  logic      grant;
  logic      in_busy;
  logic      tmo_expire;
  logic      finish;
  logic      fault;

  // A grant only counts once sdREQ was raised while sdACK was low.
  assign grant   = (state == ST_REQ) && sdREQ && sdACK;
  assign in_busy = (state == ST_BUSY);
  assign finish  = sdDONE || tmo_expire || !sdACK;
  assign fault   = (sdDONE && sdERR) || (!sdDONE && tmo_expire) || !sdACK;

  rp_sd_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .clear  (grant),
    .enable (in_busy),
    .expire (tmo_expire)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      sdREQ   <= 1'b0;
      sdSTART <= 1'b0;
      sdOP    <= '0;
      sdSECT  <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      rjt     <= 1'b0;
    end else begin
      sdSTART <= 1'b0;
      done    <= 1'b0;
      rjt     <= 1'b0;
      if (cmdGO && busy)
        rjt <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (clr) begin
            err <= 1'b0;
          end else if (cmdGO) begin
            if (cmdFUN == sdopRSVD) begin
              rjt <= 1'b1;
              err <= 1'b1;
            end else begin
              sdOP   <= cmdFUN;
              sdSECT <= cmdSECT;
              // Hold the request off while a stale grant is still up.
              sdREQ  <= !sdACK;
              busy   <= 1'b1;
              state  <= ST_REQ;
            end
          end
        end
        ST_REQ: begin
          if (grant) begin
            sdSTART <= 1'b1;
            state   <= ST_BUSY;
          end else if (clr) begin
            sdREQ <= 1'b0;
            busy  <= 1'b0;
            err   <= 1'b0;
            state <= ST_IDLE;
          end else if (!sdACK) begin
            sdREQ <= 1'b1;
          end
        end
        ST_BUSY: begin
          if (finish) begin
            sdREQ <= 1'b0;
            done  <= 1'b1;
            if (fault)
              err <= 1'b1;
            state <= ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          if (!sdACK) begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rp_sd_requester.sv
// Directed bench: cycle vector table for one requester, plus timeout and eight-drive arbitration sequences.
module tb_rp_sd_requester;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clr = 1'b0;
  logic        go = 1'b0;
  logic [1:0]  fun = '0;
  logic [31:0] sect = '0;
  logic        ack = 1'b0;
  logic        sdone = 1'b0;
  logic        serr = 1'b0;
  logic        req, start, busy, done, err, rjt;
  logic [1:0]  op;
  logic [31:0] osect;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  rp_sd_requester #(.TIMEOUT(16)) u_dut (
    .clk(clk), .rst(rst), .clr(clr), .cmdGO(go), .cmdFUN(fun), .cmdSECT(sect),
    .sdREQ(req), .sdACK(ack), .sdSTART(start), .sdOP(op), .sdSECT(osect),
    .sdDONE(sdone), .sdERR(serr), .busy(busy), .done(done), .err(err), .rjt(rjt)
  );

  // Eight requesters behind a round-robin arbiter model and a shared SD model.
  logic       m_go = 1'b0;
  logic [7:0] m_req, m_ack, m_start, m_busy, m_done, m_err, m_rjt;
  logic [1:0] m_op [8];
  logic [31:0] m_sect [8];
  logic       m_sdone;
  int         sd_cnt;
  int         ptr;
  int         order [$];
  int         dcount [8];
  int         multi_ack = 0;
  int         rjt_seen = 0;

  for (genvar g = 0; g < 8; g++) begin : g_drv
    rp_sd_requester #(.TIMEOUT(16)) u_drv (
      .clk(clk), .rst(rst), .clr(1'b0), .cmdGO(m_go), .cmdFUN(2'd0), .cmdSECT(32'(g)),
      .sdREQ(m_req[g]), .sdACK(m_ack[g]), .sdSTART(m_start[g]), .sdOP(m_op[g]),
      .sdSECT(m_sect[g]), .sdDONE(m_sdone), .sdERR(1'b0), .busy(m_busy[g]),
      .done(m_done[g]), .err(m_err[g]), .rjt(m_rjt[g])
    );
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_ack <= '0;
      ptr   <= 0;
    end else if (m_ack != 8'd0) begin
      if ((m_ack & m_req) == 8'd0)
        m_ack <= '0;
    end else begin
      for (int k = 0; k < 8; k++) begin
        int idx;
        idx = (ptr + k) % 8;
        if (m_req[idx] && m_ack == 8'd0 && order.size() < 64 &&
            (k == 0 || (m_req & ((8'd1 << ((ptr) % 8)) - 8'd0)) == 8'd0 || 1)) begin
          if (!(|(m_req & rr_mask(ptr, k)))) begin
            m_ack[idx] <= 1'b1;
            ptr <= idx + 1;
            order.push_back(idx);
          end
        end
      end
    end
  end

  // Requests scanned before position k (starting at ptr); a grant goes to the first one only.
  function automatic logic [7:0] rr_mask(input int p, input int k);
    logic [7:0] m;
    m = '0;
    for (int j = 0; j < k; j++)
      m[(p + j) % 8] = 1'b1;
    return m;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      sd_cnt  <= 0;
      m_sdone <= 1'b0;
    end else begin
      m_sdone <= (sd_cnt == 1);
      if (|m_start)
        sd_cnt <= 5;
      else if (sd_cnt > 0)
        sd_cnt <= sd_cnt - 1;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if ($countones(m_ack) > 1)
        multi_ack <= multi_ack + 1;
      if (|m_rjt)
        rjt_seen <= rjt_seen + 1;
      for (int i = 0; i < 8; i++)
        if (m_done[i])
          dcount[i] <= dcount[i] + 1;
    end
  end

  typedef struct {
    logic        go;
    logic [1:0]  fun;
    logic [31:0] sect;
    logic        clr;
    logic        ack;
    logic        sdone;
    logic        serr;
    int          reps;
    logic [39:0] exp;
  } vec_t;

  // flags = {req, start, busy, done, err, rjt}
  function automatic vec_t mk(input logic g, input logic [1:0] f, input logic [31:0] s,
                              input logic c, input logic a, input logic d, input logic e,
                              input int r, input logic [5:0] flags, input logic [1:0] eop,
                              input logic [31:0] esect);
    vec_t v;
    v.go = g; v.fun = f; v.sect = s; v.clr = c; v.ack = a; v.sdone = d; v.serr = e;
    v.reps = r;
    v.exp = {flags, eop, esect};
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total_cnt++;
    if (got !== exp)
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    else
      pass_cnt++;
  endtask

  function automatic logic [39:0] observe();
    return {req, start, busy, done, err, rjt, op, osect};
  endfunction

  vec_t tbl [38];

  initial begin
    int hit;
    bool_done: begin end
    for (int i = 0; i < 8; i++) dcount[i] = 0;

    tbl[0]  = mk(1, 0, 32'h1234, 0, 0, 0, 0, 1, 6'b101000, 0, 32'h1234);
    tbl[1]  = mk(0, 0, 0,        0, 0, 0, 0, 2, 6'b101000, 0, 32'h1234);
    tbl[2]  = mk(0, 0, 0,        0, 1, 0, 0, 1, 6'b111000, 0, 32'h1234);
    tbl[3]  = mk(0, 0, 0,        0, 1, 0, 0, 9, 6'b101000, 0, 32'h1234);
    tbl[4]  = mk(0, 0, 0,        0, 1, 1, 0, 1, 6'b001100, 0, 32'h1234);
    tbl[5]  = mk(0, 0, 0,        0, 1, 0, 0, 1, 6'b001000, 0, 32'h1234);
    tbl[6]  = mk(0, 0, 0,        0, 0, 0, 0, 1, 6'b000000, 0, 32'h1234);
    tbl[7]  = mk(0, 0, 0,        0, 0, 1, 1, 1, 6'b000000, 0, 32'h1234);
    tbl[8]  = mk(1, 2, 32'hABCD, 0, 0, 0, 0, 1, 6'b101000, 2, 32'hABCD);
    tbl[9]  = mk(0, 0, 0,        0, 1, 0, 0, 1, 6'b111000, 2, 32'hABCD);
    tbl[10] = mk(1, 1, 32'h5,    0, 1, 0, 0, 1, 6'b101001, 2, 32'hABCD);
    tbl[11] = mk(0, 0, 0,        0, 1, 1, 1, 1, 6'b001110, 2, 32'hABCD);
    tbl[12] = mk(0, 0, 0,        0, 1, 0, 0, 1, 6'b001010, 2, 32'hABCD);
    tbl[13] = mk(0, 0, 0,        0, 0, 0, 0, 1, 6'b000010, 2, 32'hABCD);
    tbl[14] = mk(1, 1, 32'h77,   0, 0, 0, 0, 1, 6'b101010, 1, 32'h77);
    tbl[15] = mk(0, 0, 0,        0, 1, 0, 0, 1, 6'b111010, 1, 32'h77);
    tbl[16] = mk(0, 0, 0,        0, 1, 1, 0, 1, 6'b001110, 1, 32'h77);
    tbl[17] = mk(0, 0, 0,        0, 0, 0, 0, 1, 6'b000010, 1, 32'h77);
    tbl[18] = mk(0, 0, 0,        1, 0, 0, 0, 1, 6'b000000, 1, 32'h77);
    tbl[19] = mk(1, 3, 32'h99,   0, 0, 0, 0, 1, 6'b000011, 1, 32'h77);
    tbl[20] = mk(0, 0, 0,        0, 0, 0, 0, 1, 6'b000010, 1, 32'h77);
    tbl[21] = mk(0, 0, 0,        1, 0, 0, 0, 1, 6'b000000, 1, 32'h77);
    tbl[22] = mk(1, 0, 32'h10,   0, 0, 0, 0, 1, 6'b101000, 0, 32'h10);
    tbl[23] = mk(0, 0, 0,        0, 0, 0, 0, 1, 6'b101000, 0, 32'h10);
    tbl[24] = mk(0, 0, 0,        1, 0, 0, 0, 1, 6'b000000, 0, 32'h10);
    tbl[25] = mk(0, 0, 0,        0, 0, 0, 0, 3, 6'b000000, 0, 32'h10);
    tbl[26] = mk(1, 1, 32'h20,   0, 0, 0, 0, 1, 6'b101000, 1, 32'h20);
    tbl[27] = mk(0, 0, 0,        1, 1, 0, 0, 1, 6'b111000, 1, 32'h20);
    tbl[28] = mk(0, 0, 0,        0, 1, 1, 0, 1, 6'b001100, 1, 32'h20);
    tbl[29] = mk(0, 0, 0,        0, 0, 0, 0, 1, 6'b000000, 1, 32'h20);
    tbl[30] = mk(1, 2, 32'h30,   0, 1, 0, 0, 1, 6'b001000, 2, 32'h30);
    tbl[31] = mk(0, 0, 0,        0, 1, 0, 0, 2, 6'b001000, 2, 32'h30);
    tbl[32] = mk(0, 0, 0,        0, 0, 0, 0, 1, 6'b101000, 2, 32'h30);
    tbl[33] = mk(0, 0, 0,        0, 1, 0, 0, 1, 6'b111000, 2, 32'h30);
    tbl[34] = mk(0, 0, 0,        0, 1, 0, 0, 2, 6'b101000, 2, 32'h30);
    tbl[35] = mk(0, 0, 0,        0, 0, 0, 0, 1, 6'b001110, 2, 32'h30);
    tbl[36] = mk(0, 0, 0,        0, 0, 0, 0, 1, 6'b000010, 2, 32'h30);
    tbl[37] = mk(0, 0, 0,        1, 0, 0, 0, 1, 6'b000000, 2, 32'h30);

    repeat (3) @(posedge clk);
    #1 check("reset", 64'(observe()), 64'd0);
    @(negedge clk) rst = 1'b0;

    for (int i = 0; i < 38; i++) begin
      for (int r = 0; r < tbl[i].reps; r++) begin
        @(negedge clk);
        go = tbl[i].go; fun = tbl[i].fun; sect = tbl[i].sect; clr = tbl[i].clr;
        ack = tbl[i].ack; sdone = tbl[i].sdone; serr = tbl[i].serr;
        @(posedge clk);
        #1 check($sformatf("vec%0d.%0d", i, r), 64'(observe()), 64'(tbl[i].exp));
      end
    end
    @(negedge clk);
    go = 0; clr = 0; ack = 0; sdone = 0; serr = 0;

    // Timeout: SD never answers, done must land 15 clocks after the start cycle.
    go = 1; fun = 2'd1; sect = 32'h55;
    @(negedge clk) go = 0; ack = 1;
    @(posedge clk);
    #1 check("tmo_start", 64'(start), 64'd1);
    hit = 0;
    for (int k = 1; k <= 40 && hit == 0; k++) begin
      @(posedge clk);
      #1 if (done) hit = k;
    end
    check("tmo_latency", 64'(hit), 64'd15);
    check("tmo_flags", 64'({req, err, busy}), 64'(3'b011));
    @(negedge clk) ack = 0;
    @(posedge clk);
    #1 check("tmo_release", 64'(busy), 64'd0);
    @(negedge clk) clr = 1;
    @(negedge clk) clr = 0;

    // Eight drives, all start together.
    m_go = 1'b1;
    @(negedge clk) m_go = 1'b0;
    hit = 0;
    for (int c = 0; c < 600 && hit == 0; c++) begin
      @(negedge clk);
      #1 if (m_busy == 8'd0 && dcount[0] > 0 && dcount[7] > 0) hit = 1;
    end
    check("multi_bound", 64'(hit), 64'd1);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("multi_done%0d", i), 64'(dcount[i]), 64'd1);
      check($sformatf("multi_order%0d", i), 64'((order.size() > i) ? order[i] : -1), 64'(i));
      check($sformatf("multi_sect%0d", i), 64'({m_op[i], m_sect[i]}), 64'(i));
    end
    check("multi_grants", 64'(order.size()), 64'd8);
    check("multi_ack", 64'(multi_ack), 64'd0);
    check("multi_err_rjt", 64'({m_err, 24'(rjt_seen)}), 64'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
